l2_reqs_table: RTL and testbench
================================

L2_REQS_TABLE -- requirements
Module: l2_reqs_table

Interface
REQ-001 SHALL have parameter N_ENTRIES, default 4, number of request entries (2..16).
REQ-002 SHALL have parameter TAG_BITS, default 16, tag width.
REQ-003 SHALL have parameter SET_BITS, default 8, set index width.
REQ-004 SHALL have parameter STATE_BITS, default 4, unstable-state width; state value 0 means INVALID.
REQ-005 SHALL derive IDX_BITS = $clog2(N_ENTRIES) and CNT_BITS = $clog2(N_ENTRIES+1).
REQ-006 SHALL have one clock and a synchronous, active-high reset: clk  in  1  clock; rst  in  1  synchronous active-high reset.
REQ-007 alloc_valid  in  1  allocation request.
REQ-008 alloc_ready  out  1  allocation accepted this cycle when also alloc_valid.
REQ-009 alloc_tag / alloc_set / alloc_state  in  TAG_BITS / SET_BITS / STATE_BITS  new entry contents.
REQ-010 alloc_idx  out  IDX_BITS  index the allocation uses (combinational).
REQ-011 alloc_conflict  out  1  a valid entry holds alloc_set (combinational).
REQ-012 wr_state_valid  in  1  state update; wr_state_idx  in  IDX_BITS; wr_state_data  in  STATE_BITS.
REQ-013 lookup_valid  in  1; lookup_tag  in  TAG_BITS; lookup_set  in  SET_BITS.
REQ-014 lookup_hit  out  1; lookup_idx  out  IDX_BITS; lookup_state  out  STATE_BITS  registered lookup result.
REQ-015 count  out  CNT_BITS  number of valid entries; full  out  1; empty  out  1.

Function
REQ-016 Entry valid SHALL be defined as state != 0; no separate valid bit.
REQ-017 alloc_idx SHALL be the lowest-index invalid entry; 0 when full.
REQ-018 alloc_conflict SHALL be 1 when any valid entry's set equals alloc_set, evaluated on registered contents only.
REQ-019 alloc_ready SHALL equal !full && !alloc_conflict; it SHALL NOT depend on same-cycle wr_state (no retire bypass).
REQ-020 On alloc_valid && alloc_ready, entry alloc_idx SHALL load tag, set, state at the next edge; alloc_state of 0 SHALL still be accepted but leaves the entry invalid and count unchanged.
REQ-021 wr_state_valid SHALL update the state of entry wr_state_idx only if that entry is currently valid; writes to invalid entries are dropped.
REQ-022 wr_state_data == 0 SHALL retire the entry; tag/set are retained but ignored.
REQ-023 Same-cycle alloc and wr_state SHALL both take effect; they cannot target the same index (alloc targets invalid, wr_state valid).
REQ-024 count SHALL be +1 on effective allocation, -1 on effective retire, unchanged when both or neither occur; full = (count == N_ENTRIES), empty = (count == 0), both registered-consistent with entry states.
REQ-025 Lookup latency SHALL be 1 cycle: lookup_hit/idx/state update on the edge after lookup_valid and hold otherwise.
REQ-026 lookup hit SHALL require valid && tag match && set match on pre-edge contents; at most one entry can match (guaranteed by REQ-019); on miss lookup_idx = 0, lookup_state = 0.
REQ-027 Lookup SHALL not observe same-cycle allocation or state writes.

Reset
REQ-028 On rst all entry states, tags and sets SHALL become 0; count = 0, empty = 1, full = 0, lookup_hit = 0, lookup_idx = 0, lookup_state = 0.
REQ-029 rst SHALL override any same-cycle alloc, wr_state or lookup; mid-operation reset discards all entries.

Verification
REQ-030 N=4: alloc sets 1,2,3,4 back-to-back, state 5 -> alloc_idx 0,1,2,3, count 4, full = 1, alloc_ready = 0 with set 9.
REQ-031 Full table, wr_state idx 2 data 0 and alloc set 9 same cycle -> alloc refused; next cycle alloc_idx = 2, alloc_ready = 1.
REQ-032 Entry 0 valid set 1; alloc set 1 -> alloc_conflict = 1, alloc_ready = 0; retire entry 0 -> alloc_ready = 1 next cycle.
REQ-033 Entry 1 tag 0xAB set 3 state 6; lookup tag 0xAB set 3 -> next cycle lookup_hit = 1, idx = 1, state = 6; tag 0xAC -> hit = 0, idx = 0.
REQ-034 wr_state to invalid idx 3 data 7 -> entry 3 stays invalid, count unchanged.
REQ-035 Three entries valid, assert rst with alloc_valid -> count 0, empty 1, lookup of any old entry misses.

Source files
------------

// File: rtl/l2_reqs_table.sv
// L2 outstanding-request table: allocates the lowest free entry, refuses an
// allocation whose set is already in flight, and answers tag/set lookups one cycle later.
module l2_reqs_table #(
  parameter int N_ENTRIES  = 4,
  parameter int TAG_BITS   = 16,
  parameter int SET_BITS   = 8,
  parameter int STATE_BITS = 4,
  localparam int IDX_BITS  = $clog2(N_ENTRIES),
  localparam int CNT_BITS  = $clog2(N_ENTRIES + 1)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  alloc_valid,
  output logic                  alloc_ready,
  input  logic [TAG_BITS-1:0]   alloc_tag,
  input  logic [SET_BITS-1:0]   alloc_set,
  input  logic [STATE_BITS-1:0] alloc_state,
  output logic [IDX_BITS-1:0]   alloc_idx,
  output logic                  alloc_conflict,
  input  logic                  wr_state_valid,
  input  logic [IDX_BITS-1:0]   wr_state_idx,
  input  logic [STATE_BITS-1:0] wr_state_data,
  input  logic                  lookup_valid,
  input  logic [TAG_BITS-1:0]   lookup_tag,
  input  logic [SET_BITS-1:0]   lookup_set,
  output logic                  lookup_hit,
  output logic [IDX_BITS-1:0]   lookup_idx,
  output logic [STATE_BITS-1:0] lookup_state,
  output logic [CNT_BITS-1:0]   count,
  output logic                  full,
  output logic                  empty
);

  logic [STATE_BITS-1:0] states [N_ENTRIES];
  logic [TAG_BITS-1:0]   tags   [N_ENTRIES];
  logic [SET_BITS-1:0]   sets   [N_ENTRIES];
  logic [N_ENTRIES-1:0]  valid;

  logic                  alloc_fire, alloc_eff, wr_eff, retire;
  logic                  lk_hit;
  logic [IDX_BITS-1:0]   lk_idx;
  logic [STATE_BITS-1:0] lk_state;
  logic [CNT_BITS-1:0]   count_nxt;

  always_comb begin
    for (int i = 0; i < N_ENTRIES; i++) valid[i] = (states[i] != '0);
  end

  // Scan downward so the lowest free index wins; stays 0 when nothing is free.
  always_comb begin
    alloc_idx      = '0;
    alloc_conflict = 1'b0;
    for (int i = N_ENTRIES - 1; i >= 0; i--) begin
      if (!valid[i]) alloc_idx = IDX_BITS'(i);
      if (valid[i] && sets[i] == alloc_set) alloc_conflict = 1'b1;
    end
  end

  assign full        = (count == CNT_BITS'(N_ENTRIES));
  assign empty       = (count == '0);
  assign alloc_ready = !full && !alloc_conflict;
  assign alloc_fire  = alloc_valid && alloc_ready;
  assign alloc_eff   = alloc_fire && (alloc_state != '0);

  // Loop compare keeps out-of-range indices harmless for non-power-of-two sizes.
  always_comb begin
    wr_eff = 1'b0;
    for (int i = 0; i < N_ENTRIES; i++) begin
      if (wr_state_valid && wr_state_idx == IDX_BITS'(i) && valid[i]) wr_eff = 1'b1;
    end
  end

  assign retire = wr_eff && (wr_state_data == '0);

  always_comb begin
    count_nxt = count;
    if (alloc_eff && !retire) count_nxt = count + 1'b1;
    else if (!alloc_eff && retire) count_nxt = count - 1'b1;
  end

  always_comb begin
    lk_hit   = 1'b0;
    lk_idx   = '0;
    lk_state = '0;
    for (int i = 0; i < N_ENTRIES; i++) begin
      if (valid[i] && tags[i] == lookup_tag && sets[i] == lookup_set) begin
        lk_hit   = 1'b1;
        lk_idx   = IDX_BITS'(i);
        lk_state = states[i];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < N_ENTRIES; i++) begin
        states[i] <= '0;
        tags[i]   <= '0;
        sets[i]   <= '0;
      end
      count        <= '0;
      lookup_hit   <= 1'b0;
      lookup_idx   <= '0;
      lookup_state <= '0;
    end else begin
      // Alloc only targets invalid entries and wr_state only valid ones, so they never collide.
      for (int i = 0; i < N_ENTRIES; i++) begin
        if (alloc_fire && alloc_idx == IDX_BITS'(i)) begin
          tags[i]   <= alloc_tag;
          sets[i]   <= alloc_set;
          states[i] <= alloc_state;
        end
        if (wr_eff && wr_state_idx == IDX_BITS'(i)) states[i] <= wr_state_data;
      end
      count <= count_nxt;
      if (lookup_valid) begin
        lookup_hit   <= lk_hit;
        lookup_idx   <= lk_idx;
        lookup_state <= lk_state;
      end
    end
  end

endmodule

// File: tb/tb_l2_reqs_table.sv
// Directed-vector bench for l2_reqs_table (N_ENTRIES=4): combinational outputs
// are checked before each edge, registered outputs just after it.
module tb_l2_reqs_table;

  logic        clk = 1'b0;
  logic        rst;
  logic        alloc_valid, alloc_ready, alloc_conflict;
  logic [15:0] alloc_tag;
  logic [7:0]  alloc_set;
  logic [3:0]  alloc_state;
  logic [1:0]  alloc_idx;
  logic        wr_state_valid;
  logic [1:0]  wr_state_idx;
  logic [3:0]  wr_state_data;
  logic        lookup_valid, lookup_hit;
  logic [15:0] lookup_tag;
  logic [7:0]  lookup_set;
  logic [1:0]  lookup_idx;
  logic [3:0]  lookup_state;
  logic [2:0]  count;
  logic        full, empty;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  l2_reqs_table #(.N_ENTRIES(4), .TAG_BITS(16), .SET_BITS(8), .STATE_BITS(4)) dut (
    .clk(clk), .rst(rst),
    .alloc_valid(alloc_valid), .alloc_ready(alloc_ready),
    .alloc_tag(alloc_tag), .alloc_set(alloc_set), .alloc_state(alloc_state),
    .alloc_idx(alloc_idx), .alloc_conflict(alloc_conflict),
    .wr_state_valid(wr_state_valid), .wr_state_idx(wr_state_idx), .wr_state_data(wr_state_data),
    .lookup_valid(lookup_valid), .lookup_tag(lookup_tag), .lookup_set(lookup_set),
    .lookup_hit(lookup_hit), .lookup_idx(lookup_idx), .lookup_state(lookup_state),
    .count(count), .full(full), .empty(empty)
  );

  typedef struct {
    logic        rst;
    logic        av;
    logic [15:0] atag;
    logic [7:0]  aset;
    logic [3:0]  ast;
    logic        wv;
    logic [1:0]  widx;
    logic [3:0]  wd;
    logic        lv;
    logic [15:0] ltag;
    logic [7:0]  lset;
    logic [1:0]  e_aidx;
    logic        e_ardy;
    logic        e_conf;
    logic [2:0]  e_cnt;
    logic        e_hit;
    logic [1:0]  e_lidx;
    logic [3:0]  e_lst;
  } vec_t;

  function automatic vec_t mk(int r, int av, int atag, int aset, int ast,
                              int wv, int widx, int wd, int lv, int ltag, int lset,
                              int aidx, int ardy, int conf, int cnt, int hit, int lidx, int lst);
    vec_t v;
    v.rst = 1'(r);     v.av = 1'(av);        v.atag = 16'(atag); v.aset = 8'(aset);
    v.ast = 4'(ast);   v.wv = 1'(wv);        v.widx = 2'(widx);  v.wd = 4'(wd);
    v.lv = 1'(lv);     v.ltag = 16'(ltag);   v.lset = 8'(lset);
    v.e_aidx = 2'(aidx); v.e_ardy = 1'(ardy); v.e_conf = 1'(conf);
    v.e_cnt = 3'(cnt); v.e_hit = 1'(hit);    v.e_lidx = 2'(lidx); v.e_lst = 4'(lst);
    return v;
  endfunction

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic check_regs(input string tag, input int cnt, input int hit, input int lidx, input int lst);
    check({tag, " count"}, int'(count), cnt);
    check({tag, " full"}, int'(full), int'(cnt == 4));
    check({tag, " empty"}, int'(empty), int'(cnt == 0));
    check({tag, " lookup_hit"}, int'(lookup_hit), hit);
    check({tag, " lookup_idx"}, int'(lookup_idx), lidx);
    check({tag, " lookup_state"}, int'(lookup_state), lst);
  endtask

  vec_t vecs[24];

  initial begin
    //             rst av atag  aset ast  wv wi wd  lv ltag  lset  aidx rdy cf cnt hit li ls
    vecs[0]  = mk(0, 1, 'h10,  1, 5,   0, 0, 0,  0, 0,    0,    0, 1, 0, 1, 0, 0, 0);
    vecs[1]  = mk(0, 1, 'h11,  2, 5,   0, 0, 0,  0, 0,    0,    1, 1, 0, 2, 0, 0, 0);
    vecs[2]  = mk(0, 1, 'h12,  3, 5,   0, 0, 0,  0, 0,    0,    2, 1, 0, 3, 0, 0, 0);
    vecs[3]  = mk(0, 1, 'h13,  4, 5,   0, 0, 0,  0, 0,    0,    3, 1, 0, 4, 0, 0, 0);
    vecs[4]  = mk(0, 1, 'h99,  9, 5,   0, 0, 0,  1, 'h12, 3,    0, 0, 0, 4, 1, 2, 5);
    vecs[5]  = mk(0, 1, 'h99,  9, 5,   1, 2, 0,  0, 0,    0,    0, 0, 0, 3, 1, 2, 5);
    vecs[6]  = mk(0, 1, 'h20,  9, 7,   0, 0, 0,  1, 'h20, 9,    2, 1, 0, 4, 0, 0, 0);
    vecs[7]  = mk(0, 0, 0,     0, 0,   1, 0, 6,  1, 'h20, 9,    0, 0, 0, 4, 1, 2, 7);
    vecs[8]  = mk(0, 0, 0,     0, 0,   1, 0, 0,  1, 'h10, 1,    0, 0, 0, 3, 1, 0, 6);
    vecs[9]  = mk(0, 1, 'h77,  2, 5,   0, 0, 0,  0, 0,    0,    0, 0, 1, 3, 1, 0, 6);
    vecs[10] = mk(0, 1, 'h77,  2, 5,   1, 1, 0,  0, 0,    0,    0, 0, 1, 2, 1, 0, 6);
    vecs[11] = mk(0, 1, 'h30,  2, 3,   0, 0, 0,  0, 0,    0,    0, 1, 0, 3, 1, 0, 6);
    vecs[12] = mk(0, 0, 0,     0, 0,   1, 1, 7,  1, 'h11, 2,    1, 1, 0, 3, 0, 0, 0);
    vecs[13] = mk(0, 1, 'h40,  5, 0,   0, 0, 0,  0, 0,    0,    1, 1, 0, 3, 0, 0, 0);
    vecs[14] = mk(0, 0, 0,     0, 0,   0, 0, 0,  1, 'h30, 2,    1, 1, 0, 3, 1, 0, 3);
    vecs[15] = mk(1, 1, 'h66,  6, 5,   1, 0, 0,  1, 'h13, 4,    1, 1, 0, 0, 0, 0, 0);
    vecs[16] = mk(0, 0, 0,     0, 0,   0, 0, 0,  1, 'h13, 4,    0, 1, 0, 0, 0, 0, 0);
    vecs[17] = mk(0, 1, 'h01,  7, 2,   0, 0, 0,  0, 0,    0,    0, 1, 0, 1, 0, 0, 0);
    vecs[18] = mk(0, 1, 'hAB,  3, 6,   0, 0, 0,  0, 0,    0,    1, 1, 0, 2, 0, 0, 0);
    vecs[19] = mk(0, 0, 0,     0, 0,   0, 0, 0,  1, 'hAB, 3,    2, 1, 0, 2, 1, 1, 6);
    vecs[20] = mk(0, 0, 0,     0, 0,   0, 0, 0,  1, 'hAC, 3,    2, 1, 0, 2, 0, 0, 0);
    vecs[21] = mk(0, 1, 'h50,  8, 1,   1, 1, 9,  0, 0,    0,    2, 1, 0, 3, 0, 0, 0);
    vecs[22] = mk(0, 1, 'h60, 10, 4,   1, 0, 0,  1, 'hAB, 3,    3, 1, 0, 3, 1, 1, 9);
    vecs[23] = mk(0, 0, 0,     0, 0,   0, 0, 0,  1, 'h60, 10,   0, 1, 0, 3, 1, 3, 4);

    // Power-on reset held for two cycles with idle inputs.
    rst = 1'b1; alloc_valid = 1'b0; alloc_tag = '0; alloc_set = '0; alloc_state = '0;
    wr_state_valid = 1'b0; wr_state_idx = '0; wr_state_data = '0;
    lookup_valid = 1'b0; lookup_tag = '0; lookup_set = '0;
    repeat (2) @(posedge clk);
    #1;
    check_regs("reset", 0, 0, 0, 0);
    check("reset alloc_idx", int'(alloc_idx), 0);
    check("reset alloc_ready", int'(alloc_ready), 1);

    for (int i = 0; i < 24; i++) begin
      @(negedge clk);
      rst            = vecs[i].rst;
      alloc_valid    = vecs[i].av;
      alloc_tag      = vecs[i].atag;
      alloc_set      = vecs[i].aset;
      alloc_state    = vecs[i].ast;
      wr_state_valid = vecs[i].wv;
      wr_state_idx   = vecs[i].widx;
      wr_state_data  = vecs[i].wd;
      lookup_valid   = vecs[i].lv;
      lookup_tag     = vecs[i].ltag;
      lookup_set     = vecs[i].lset;
      #1;
      check($sformatf("v%0d alloc_idx", i), int'(alloc_idx), int'(vecs[i].e_aidx));
      check($sformatf("v%0d alloc_ready", i), int'(alloc_ready), int'(vecs[i].e_ardy));
      check($sformatf("v%0d alloc_conflict", i), int'(alloc_conflict), int'(vecs[i].e_conf));
      @(posedge clk);
      #1;
      check_regs($sformatf("v%0d", i), int'(vecs[i].e_cnt), int'(vecs[i].e_hit),
                 int'(vecs[i].e_lidx), int'(vecs[i].e_lst));
    end

    // Held lookup: with lookup_valid low the last result must persist across cycles.
    @(negedge clk);
    rst = 1'b0; alloc_valid = 1'b0; wr_state_valid = 1'b0; lookup_valid = 1'b0;
    alloc_set = '0;
    repeat (3) @(posedge clk);
    #1;
    check_regs("hold", 3, 1, 3, 4);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
